multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Main control FSM for the multicycle ARMv4 core. Sequences the single shared ALU,
//  memory port and register file over several cycles per instruction.
//  Drives ALUOp into ALU_DECODER, which turns Funct into ALUControl/FlagW.
//  Sits in the controller beside the condition-check logic; that logic gates RegW/MemW/Branch.
// PARAMETERS
//  none (state encoding fixed: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5
//        EXECR=6 EXECI=7 ALUWB=8 BRANCH=9; codes 10..15 illegal)
// PORTS
//  clk        in   1  single clock, all state updates on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  Op         in   2  Instr[27:26] from instruction register
//  Funct      in   6  Instr[25:20]; [5]=I (immediate), [0]=S/L (load)
//  MemReady   in   1  memory handshake: access completes in a cycle where 1
//  IRWrite    out  1  load instruction register
//  NextPC     out  1  write PC with ALU result (PC+4)
//  RegW       out  1  register-file write (pre condition gating)
//  MemW       out  1  memory write request (pre condition gating)
//  Branch     out  1  branch write of PC (pre condition gating)
//  AdrSrc     out  1  0=PC, 1=ALU result register to memory address
//  ALUSrcA    out  1  0=register A, 1=PC
//  ALUSrcB    out  2  00=register B, 01=ExtImm, 10=constant 4
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result (bypass)
//  ALUOp      out  1  1=data-processing decode in ALU_DECODER, 0=force ADD
//  InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
//  State      out  4  current state code (debug)
// BEHAVIOUR
//  Reset: rst_n=0 puts State in FETCH asynchronously. IRWrite, NextPC, RegW, MemW,
//   Branch and InstrDone are forced 0 while rst_n=0. Selects show FETCH values.
//   Reset mid-instruction abandons the instruction; nothing is written.
//  Moore outputs from State, except the MemReady-qualified strobes below.
//   Unlisted outputs are 0.
//  FETCH : AdrSrc=0 ALUSrcA=1 ALUSrcB=10 ResultSrc=10.
//          IRWrite=NextPC=MemReady. Stay while MemReady=0, else go to DECODE.
//  DECODE: ALUSrcA=1 ALUSrcB=10 ResultSrc=10 (PC+8 read).
//          Op=01 -> MEMADR.
//          Op=00 -> EXECI if Funct[5]=1, else EXECR.
//          Op=10 -> BRANCH.
//          Op=11 (undefined) -> FETCH with InstrDone=1 (NOP).
//  MEMADR: ALUSrcA=0 ALUSrcB=01. Go to MEMRD if Funct[0]=1, else MEMWR.
//  MEMRD : AdrSrc=1. Stay while MemReady=0, else go to MEMWB.
//  MEMWB : ResultSrc=01 RegW=1 InstrDone=1. Go to FETCH.
//  MEMWR : AdrSrc=1 MemW=1, held every cycle of the wait.
//          InstrDone=MemReady. Stay while MemReady=0, else go to FETCH.
//  EXECR : ALUSrcA=0 ALUSrcB=00 ALUOp=1. Go to ALUWB.
//  EXECI : ALUSrcA=0 ALUSrcB=01 ALUOp=1. Go to ALUWB.
//  ALUWB : ResultSrc=00 RegW=1 InstrDone=1. Go to FETCH.
//  BRANCH: ALUSrcA=0 ALUSrcB=01 ResultSrc=10 Branch=1 InstrDone=1. Go to FETCH.
//  Illegal state code: all outputs 0, next state FETCH.
//  Latency with MemReady=1 always: LDR 5 cycles, STR 4, DP 4, B 3, undefined 2.
//   Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
//  Op/Funct are sampled only in DECODE/MEMADR; changes at other times are ignored.
// TESTING
//  Reset: assert rst_n=0 mid-EXECR -> State=0 immediately; strobes 0; FETCH resumes after release.
//  ADD R (Op=00, Funct=001000), MemReady=1 -> FETCH,DECODE,EXECR(ALUOp=1),ALUWB(RegW=1); InstrDone on cycle 4.
//  LDR (Op=01, Funct[0]=1), MemReady low 2 cycles in MEMRD -> MEMRD held 3 cycles, AdrSrc=1; MEMWB RegW=1; total 7 cycles.
//  STR (Op=01, Funct[0]=0), MemReady=0 in FETCH 1 cycle -> IRWrite only on ready cycle; MemW=1 in MEMWR; InstrDone once.
//  B (Op=10) -> BRANCH: Branch=1, ALUSrcB=01, ResultSrc=10; back to FETCH after 3 cycles.
//  Undefined Op=11 -> DECODE->FETCH, InstrDone=1, RegW=MemW=Branch=0 throughout.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
//==============================================================================
// Module      : multicycle_main_fsm
// Description : Main control FSM of the multicycle ARMv4 core. Steps one
//               instruction through fetch, decode and execute over several
//               cycles, sharing one ALU, one memory port and the register file.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   Op         in   2  Instr[27:26]
//   Funct      in   6  Instr[25:20]; [5]=immediate, [0]=load
//   MemReady   in   1  memory access completes in a cycle where high
//   IRWrite    out  1  load instruction register
//   NextPC     out  1  write PC with PC+4
//   RegW       out  1  register-file write (before condition gating)
//   MemW       out  1  memory write (before condition gating)
//   Branch     out  1  branch PC write (before condition gating)
//   AdrSrc     out  1  0=PC, 1=ALUOut as memory address
//   ALUSrcA    out  1  0=register A, 1=PC
//   ALUSrcB    out  2  00=register B, 01=ExtImm, 10=constant 4
//   ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result
//   ALUOp      out  1  1=data-processing decode, 0=force ADD
//   InstrDone  out  1  pulse on the final cycle of each instruction
//   State      out  4  current state code
//==============================================================================
`default_nettype none

module multicycle_main_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    // Unconditioned strobes; gated by rst_n below so nothing fires in reset.
    logic ir_write_raw;
    logic next_pc_raw;
    logic reg_w_raw;
    logic mem_w_raw;
    logic branch_raw;
    logic done_raw;

    // Only the I and L bits of Funct steer this FSM.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = FETCH;
        ir_write_raw = 1'b0;
        next_pc_raw  = 1'b0;
        reg_w_raw    = 1'b0;
        mem_w_raw    = 1'b0;
        branch_raw   = 1'b0;
        done_raw     = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ALUOp        = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = MemReady;
                next_pc_raw  = MemReady;
                state_d      = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU forms PC+8 for the register-file R15 read.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        // Undefined class retires as a NOP right here.
                        state_d  = FETCH;
                        done_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w_raw = 1'b1;
                done_raw  = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                // Write request stays up for the whole memory wait.
                AdrSrc    = 1'b1;
                mem_w_raw = 1'b1;
                done_raw  = MemReady;
                state_d   = MemReady ? FETCH : MEMWR;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_w_raw = 1'b1;
                done_raw  = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch_raw = 1'b1;
                done_raw   = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                // Illegal codes 10..15: all outputs stay 0, recover to FETCH.
                state_d = FETCH;
            end
        endcase
    end

    assign IRWrite   = rst_n & ir_write_raw;
    assign NextPC    = rst_n & next_pc_raw;
    assign RegW      = rst_n & reg_w_raw;
    assign MemW      = rst_n & mem_w_raw;
    assign Branch    = rst_n & branch_raw;
    assign InstrDone = rst_n & done_raw;
    assign State     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
//==============================================================================
// Module      : tb_multicycle_main_fsm
// Description : Self-checking bench for multicycle_main_fsm. Each scenario
//               queues the expected per-cycle state/output vector together
//               with the MemReady value to drive, then pops and compares one
//               entry per clock.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       InstrDone;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    multicycle_main_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .InstrDone (InstrDone),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {State, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
    //  ALUSrcB, ResultSrc, ALUOp, InstrDone}
    logic [16:0] dut_vec;
    assign dut_vec = {State, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone};

    typedef struct packed {
        logic [3:0]  st;
        logic        mr;
        logic [16:0] exp;
    } step_t;

    step_t sb_q[$];

    logic [1:0] cur_op;
    logic [5:0] cur_funct;

    // Output table of the control unit, keyed by state code.
    function automatic logic [16:0] golden(input logic [3:0] st, input logic mr,
                                           input logic [1:0] op);
        logic irw, npc, rw, mw, br, adr, sa, al, dn;
        logic [1:0] sb, rs;
        {irw, npc, rw, mw, br, adr, sa, al, dn} = '0;
        sb = 2'b00;
        rs = 2'b00;
        case (st)
            4'd0: begin sa = 1; sb = 2'b10; rs = 2'b10; irw = mr; npc = mr; end
            4'd1: begin sa = 1; sb = 2'b10; rs = 2'b10; dn = (op == 2'b11); end
            4'd2: begin sb = 2'b01; end
            4'd3: begin adr = 1; end
            4'd4: begin rs = 2'b01; rw = 1; dn = 1; end
            4'd5: begin adr = 1; mw = 1; dn = mr; end
            4'd6: begin al = 1; end
            4'd7: begin sb = 2'b01; al = 1; end
            4'd8: begin rs = 2'b00; rw = 1; dn = 1; end
            4'd9: begin sb = 2'b01; rs = 2'b10; br = 1; dn = 1; end
            default: ;
        endcase
        return {st, irw, npc, rw, mw, br, adr, sa, sb, rs, al, dn};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr);
        step_t e;
        e.st  = st;
        e.mr  = mr;
        e.exp = golden(st, mr, cur_op);
        sb_q.push_back(e);
    endtask

    // Drains the scoreboard one clock per entry. Op/Funct hold the
    // instruction only in DECODE/MEMADR and are scrambled elsewhere.
    task automatic run(input string name, input int exp_dones);
        step_t e;
        int cyc   = 0;
        int dones = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            MemReady = e.mr;
            if (e.st == 4'd1 || e.st == 4'd2) begin
                Op    = cur_op;
                Funct = cur_funct;
            end else begin
                Op    = 2'($urandom);
                Funct = 6'($urandom);
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== e.exp) begin
                failures++;
                $display("FAIL %s cycle %0d: vec actual=%b required=%b",
                         name, cyc, dut_vec, e.exp);
            end
            if (InstrDone === 1'b1) dones++;
            cyc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dones !== exp_dones) begin
            failures++;
            $display("FAIL %s done_count: actual=%0d required=%0d", name, dones, exp_dones);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        MemReady = 1'b1;
        Op       = 2'b00;
        Funct    = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({State, IRWrite, NextPC, RegW, MemW, Branch, InstrDone} !== 10'd0) begin
            failures++;
            $display("FAIL reset_state: actual=%b required=%b",
                     {State, IRWrite, NextPC, RegW, MemW, Branch, InstrDone}, 10'd0);
        end
        checks++;
        if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 6'b011010) begin
            failures++;
            $display("FAIL reset_selects: actual=%b required=%b",
                     {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 6'b011010);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        cur_op = 2'b00; cur_funct = 6'b001000;
        push(4'd0, 1); push(4'd1, 1); push(4'd6, 1); push(4'd8, 1);
        run("add_r", 1);
    endtask

    task automatic test_dp_imm();
        cur_op = 2'b00; cur_funct = 6'b101000;
        push(4'd0, 1); push(4'd1, 1); push(4'd7, 1); push(4'd8, 1);
        run("add_i", 1);
    endtask

    task automatic test_ldr_wait();
        cur_op = 2'b01; cur_funct = 6'b011001;
        push(4'd0, 1); push(4'd1, 1); push(4'd2, 1);
        push(4'd3, 0); push(4'd3, 0); push(4'd3, 1); push(4'd4, 1);
        run("ldr_wait", 1);
    endtask

    task automatic test_str_fetch_wait();
        cur_op = 2'b01; cur_funct = 6'b011000;
        push(4'd0, 0); push(4'd0, 1); push(4'd1, 1); push(4'd2, 1); push(4'd5, 1);
        run("str_fetch_wait", 1);
    endtask

    task automatic test_branch();
        cur_op = 2'b10; cur_funct = 6'b100001;
        push(4'd0, 1); push(4'd1, 1); push(4'd9, 1);
        run("branch", 1);
    endtask

    task automatic test_undef();
        cur_op = 2'b11; cur_funct = 6'b111111;
        push(4'd0, 1); push(4'd1, 1);
        run("undef", 1);
    endtask

    // Instructions chained with no idle cycles, including a MEMWR wait.
    task automatic test_back_to_back();
        cur_op = 2'b01; cur_funct = 6'b000000;
        push(4'd0, 1); push(4'd1, 1); push(4'd2, 1);
        push(4'd5, 0); push(4'd5, 0); push(4'd5, 1);
        run("b2b_str_memwait", 1);
        cur_op = 2'b10; cur_funct = 6'b000000;
        push(4'd0, 1); push(4'd1, 1); push(4'd9, 1);
        run("b2b_branch", 1);
        cur_op = 2'b01; cur_funct = 6'b000001;
        push(4'd0, 1); push(4'd1, 1); push(4'd2, 1); push(4'd3, 1); push(4'd4, 1);
        run("b2b_ldr", 1);
    endtask

    task automatic test_reset_mid_instr();
        cur_op = 2'b00; cur_funct = 6'b001000;
        push(4'd0, 1); push(4'd1, 1);
        run("mid_reset_pre", 0);
        MemReady = 1'b1;
        checks++;
        if (State !== 4'd6) begin
            failures++;
            $display("FAIL mid_reset_in_execr: State actual=%0d required=6", State);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({State, IRWrite, NextPC, RegW, MemW, Branch, InstrDone} !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset_async: actual=%b required=%b",
                     {State, IRWrite, NextPC, RegW, MemW, Branch, InstrDone}, 10'd0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({State, IRWrite, RegW, InstrDone} !== 7'd0) begin
            failures++;
            $display("FAIL mid_reset_held: actual=%b required=%b",
                     {State, IRWrite, RegW, InstrDone}, 7'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(4'd0, 1); push(4'd1, 1); push(4'd6, 1); push(4'd8, 1);
        run("mid_reset_resume", 1);
        checks++;
        if (State !== 4'd0) begin
            failures++;
            $display("FAIL final_fetch: State actual=%0d required=0", State);
        end
    endtask

    initial begin
        cur_op    = 2'b00;
        cur_funct = 6'd0;
        test_reset();
        test_add();
        test_dp_imm();
        test_ldr_wait();
        test_str_fetch_wait();
        test_branch();
        test_undef();
        test_back_to_back();
        test_reset_mid_instr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
